// File: rtl/vend_dispense_scheduler.sv
// Dispense sequencer: stock check, motor pulse, drop sense, per-slot stock and jam.
// Optional JAM_RETRY_EN: one extra motor pulse and sense window after the first timeout.
module vend_dispense_scheduler #(
  parameter int SLOT_W        = 2,
  parameter int STOCK_W       = 4,
  parameter int STOCK_INIT    = 10,
  parameter int MOTOR_CYCLES  = 8,
  parameter int SENSE_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [SLOT_W-1:0]          req_slot,
  output logic                       req_ready,
  output logic                       done_valid,
  output logic [1:0]                 done_code,
  output logic [SLOT_W-1:0]          done_slot,
  output logic [(2**SLOT_W)-1:0]     motor_en,
  input  logic                       drop_sense,
  input  logic                       restock_valid,
  input  logic [SLOT_W-1:0]          restock_slot,
  input  logic [STOCK_W-1:0]         restock_qty,
  output logic [(2**SLOT_W)-1:0]     stock_avail,
  output logic                       fault
);

  localparam int NUM_SLOTS = 2**SLOT_W;
  localparam int CNT_MAX =
    (MOTOR_CYCLES > SENSE_TIMEOUT) ? MOTOR_CYCLES : SENSE_TIMEOUT;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [1:0] CODE_OK    = 2'b00;
  localparam logic [1:0] CODE_EMPTY = 2'b01;
  localparam logic [1:0] CODE_JAM   = 2'b10;

  typedef enum logic [2:0] {
    IDLE, CHECK, DRIVE, SENSE, REPORT
  } state_t;

  state_t                              state;
  logic [SLOT_W-1:0]                   slot;
  logic [CNT_W-1:0]                    cnt;
  logic                                drop_seen;
  logic [1:0]                          code;
  logic [NUM_SLOTS-1:0][STOCK_W-1:0]   stock;
  logic [NUM_SLOTS-1:0]                jam;
`ifdef JAM_RETRY_EN
  logic                                retried;
`endif

  logic [NUM_SLOTS-1:0][STOCK_W-1:0]   stock_nxt;
  logic [NUM_SLOTS-1:0]                jam_nxt;
  logic [NUM_SLOTS-1:0]                avail_nxt;
  logic [STOCK_W:0]                    sum;
  logic [NUM_SLOTS-1:0]                slot_oh;
  logic                                seen_now;

  assign slot_oh  = NUM_SLOTS'(1) << slot;
  assign seen_now = drop_seen | drop_sense;

  // Restock saturates first, so a same-cycle OK decrement lands on the sum.
  always_comb begin
    stock_nxt = stock;
    jam_nxt   = jam;
    sum       = '0;
    if (state == REPORT && code == CODE_JAM)
      jam_nxt[slot] = 1'b1;
    if (restock_valid) begin
      sum = {1'b0, stock[restock_slot]} + {1'b0, restock_qty};
      stock_nxt[restock_slot] = sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
      jam_nxt[restock_slot]   = 1'b0;
    end
    if (state == REPORT && code == CODE_OK && stock_nxt[slot] != '0)
      stock_nxt[slot] = stock_nxt[slot] - STOCK_W'(1);
    for (int i = 0; i < NUM_SLOTS; i++)
      avail_nxt[i] = (stock_nxt[i] != '0) && !jam_nxt[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      slot        <= '0;
      cnt         <= '0;
      drop_seen   <= 1'b0;
      code        <= CODE_OK;
      motor_en    <= '0;
      done_valid  <= 1'b0;
      done_code   <= CODE_OK;
      done_slot   <= '0;
      req_ready   <= 1'b1;
      stock       <= {NUM_SLOTS{STOCK_W'(STOCK_INIT)}};
      jam         <= '0;
      stock_avail <= (STOCK_INIT != 0) ? '1 : '0;
      fault       <= 1'b0;
`ifdef JAM_RETRY_EN
      retried     <= 1'b0;
`endif
    end else begin
      stock       <= stock_nxt;
      jam         <= jam_nxt;
      stock_avail <= avail_nxt;
      fault       <= |jam_nxt;
      done_valid  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            slot      <= req_slot;
            req_ready <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (stock[slot] == '0 || jam[slot]) begin
            code  <= CODE_EMPTY;
            state <= REPORT;
          end else begin
            cnt       <= CNT_W'(MOTOR_CYCLES);
            drop_seen <= 1'b0;
            motor_en  <= slot_oh;
            state     <= DRIVE;
`ifdef JAM_RETRY_EN
            retried   <= 1'b0;
`endif
          end
        end
        DRIVE: begin
          drop_seen <= seen_now;
          if (cnt == CNT_W'(1)) begin
            motor_en <= '0;
            if (seen_now) begin
              code  <= CODE_OK;
              state <= REPORT;
            end else begin
              cnt   <= CNT_W'(SENSE_TIMEOUT);
              state <= SENSE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SENSE: begin
          if (drop_sense) begin
            code  <= CODE_OK;
            state <= REPORT;
          end else if (cnt == CNT_W'(1)) begin
`ifdef JAM_RETRY_EN
            if (!retried) begin
              retried   <= 1'b1;
              cnt       <= CNT_W'(MOTOR_CYCLES);
              drop_seen <= 1'b0;
              motor_en  <= slot_oh;
              state     <= DRIVE;
            end else begin
              code  <= CODE_JAM;
              state <= REPORT;
            end
`else
            code  <= CODE_JAM;
            state <= REPORT;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        REPORT: begin
          done_valid <= 1'b1;
          done_code  <= code;
          done_slot  <= slot;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// Bench for vend_dispense_scheduler: timeline model of each vend, random traffic.
// Honours JAM_RETRY_EN the same way the design does.
module tb_vend_dispense_scheduler;

  localparam int SLOT_W = 2;
  localparam int STOCK_W = 4;
  localparam int NS = 4;
  localparam int M = 8;
  localparam int T = 16;
  localparam int SMAX = 15;
`ifdef JAM_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic [SLOT_W-1:0] req_slot = '0;
  logic req_ready;
  logic done_valid;
  logic [1:0] done_code;
  logic [SLOT_W-1:0] done_slot;
  logic [NS-1:0] motor_en;
  logic drop_sense = 1'b0;
  logic restock_valid = 1'b0;
  logic [SLOT_W-1:0] restock_slot = '0;
  logic [STOCK_W-1:0] restock_qty = '0;
  logic [NS-1:0] stock_avail;
  logic fault;

  int errors = 0;
  int checks = 0;
  int mstock[NS];
  bit mjam[NS];

  vend_dispense_scheduler #(
    .SLOT_W(SLOT_W), .STOCK_W(STOCK_W), .STOCK_INIT(10),
    .MOTOR_CYCLES(M), .SENSE_TIMEOUT(T)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_slot(req_slot), .req_ready(req_ready),
    .done_valid(done_valid), .done_code(done_code), .done_slot(done_slot),
    .motor_en(motor_en), .drop_sense(drop_sense),
    .restock_valid(restock_valid), .restock_slot(restock_slot),
    .restock_qty(restock_qty), .stock_avail(stock_avail), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic bit hit(int n, int c, int w);
    return c >= 0 && n >= c && n < c + w;
  endfunction

  function automatic int sat(int v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      mstock[i] = 10;
      mjam[i] = 0;
    end
  endtask

  task automatic check_status(input string nm);
    logic [NS-1:0] ea;
    bit ef;
    ef = 0;
    for (int i = 0; i < NS; i++) begin
      ea[i] = (mstock[i] != 0) && !mjam[i];
      ef = ef | mjam[i];
    end
    checks++;
    if (stock_avail !== ea) begin
      errors++;
      $display("FAIL %s avail: got %b want %b", nm, stock_avail, ea);
    end
    checks++;
    if (fault !== ef) begin
      errors++;
      $display("FAIL %s fault: got %b want %b", nm, fault, ef);
    end
  endtask

  // rs_mode: -1 none, -2 on the REPORT cycle, -3 random cycle, else that cycle
  task automatic vend(input int s, input int c, input int w,
                      input int rs_mode, input int rs_s, input int rs_q,
                      input string nm);
    int L, code, rs_cyc, first, npulse, mbad, rbad;
    bit rt, found, on;
    logic [1:0] gcode;
    logic [SLOT_W-1:0] gslot;
    logic [NS-1:0] em;
    rt = 0; found = 0;
    if (mstock[s] == 0 || mjam[s]) begin
      code = 1; L = 2;
    end else begin
      code = 2; L = M + T + 2;
      for (int n = 2; n <= M + 1 && !found; n++)
        if (hit(n, c, w)) begin found = 1; code = 0; L = M + 2; end
      for (int n = M + 2; n <= M + T + 1 && !found; n++)
        if (hit(n, c, w)) begin found = 1; code = 0; L = n + 1; end
      if (!found && RETRY) begin
        rt = 1; L = 2 * (M + T) + 2;
        for (int n = M + T + 2; n <= 2 * M + T + 1 && !found; n++)
          if (hit(n, c, w)) begin
            found = 1; code = 0; L = 2 * M + T + 2;
          end
        for (int n = 2 * M + T + 2; n <= 2 * (M + T) + 1 && !found; n++)
          if (hit(n, c, w)) begin found = 1; code = 0; L = n + 1; end
      end
    end
    rs_cyc = (rs_mode == -2) ? L :
             (rs_mode == -3) ? $urandom_range(1, L) : rs_mode;

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_idle: got %b want 1", nm, req_ready);
    end
    req_valid = 1'b1;
    req_slot = SLOT_W'(s);
    @(posedge clk);
    #1 req_valid = 1'b0;
    first = 0; npulse = 0; mbad = 0; rbad = 0;
    gcode = 'x; gslot = 'x;
    for (int n = 1; n <= L + 1; n++) begin
      @(negedge clk);
      drop_sense = hit(n, c, w);
      restock_valid = (n == rs_cyc);
      restock_slot = SLOT_W'(rs_s);
      restock_qty = STOCK_W'(rs_q);
      @(posedge clk);
      #1;
      on = (code != 1) &&
           ((n >= 1 && n <= M) || (rt && n >= M + T + 1 && n <= 2 * M + T));
      em = on ? (NS'(1) << s) : '0;
      if (motor_en !== em) mbad++;
      if (req_ready !== (n >= L)) rbad++;
      if (done_valid === 1'b1) begin
        npulse++;
        if (first == 0) begin
          first = n; gcode = done_code; gslot = done_slot;
        end
      end
    end
    drop_sense = 1'b0;
    restock_valid = 1'b0;

    if (rs_cyc >= 1 && rs_cyc < L) begin
      mstock[rs_s] = sat(mstock[rs_s] + rs_q);
      mjam[rs_s] = 0;
    end
    if (rs_cyc == L) mstock[rs_s] = sat(mstock[rs_s] + rs_q);
    if (code == 0) mstock[s] = mstock[s] - 1;
    if (code == 2) mjam[s] = 1;
    if (rs_cyc == L) mjam[rs_s] = 0;

    checks++;
    if (first != L) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", nm, first, L);
    end
    checks++;
    if (npulse != 1) begin
      errors++;
      $display("FAIL %s pulses: got %0d want 1", nm, npulse);
    end
    checks++;
    if (gcode !== 2'(code)) begin
      errors++;
      $display("FAIL %s code: got %b want %0d", nm, gcode, code);
    end
    checks++;
    if (gslot !== SLOT_W'(s)) begin
      errors++;
      $display("FAIL %s slot: got %0d want %0d", nm, gslot, s);
    end
    checks++;
    if (mbad != 0) begin
      errors++;
      $display("FAIL %s motor: got %0d bad cycles want 0", nm, mbad);
    end
    checks++;
    if (rbad != 0) begin
      errors++;
      $display("FAIL %s ready: got %0d bad cycles want 0", nm, rbad);
    end
    check_status(nm);
  endtask

  task automatic do_restock(input int s, input int q, input string nm);
    @(negedge clk);
    restock_valid = 1'b1;
    restock_slot = SLOT_W'(s);
    restock_qty = STOCK_W'(q);
    @(negedge clk);
    restock_valid = 1'b0;
    mstock[s] = sat(mstock[s] + q);
    mjam[s] = 0;
    @(posedge clk);
    #1 check_status(nm);
  endtask

  task automatic drain(input int s, input int n, input string nm);
    for (int i = 0; i < n; i++)
      vend(s, $urandom_range(2, M + 1), 1, -1, 0, 0, nm);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (req_ready !== 1'b1 || done_valid !== 1'b0 || motor_en !== '0 ||
        done_code !== 2'b00 || done_slot !== '0) begin
      errors++;
      $display("FAIL reset outs: got rdy=%b dv=%b mot=%b code=%b slot=%0d want 1 0 0 0 0",
               req_ready, done_valid, motor_en, done_code, done_slot);
    end
    check_status("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ok();
    vend(1, 4, 1, -1, 0, 0, "ok_slot1");
    vend(3, M + 5, 1, -1, 0, 0, "ok_in_sense");
    vend(2, 3, 4, -1, 0, 0, "multi_pulse");
  endtask

  task automatic test_empty();
    drain(2, mstock[2], "drain2");
    vend(2, 3, 1, -1, 0, 0, "empty2");
  endtask

  task automatic test_jam();
    vend(0, -1, 1, -1, 0, 0, "jam0");
    vend(0, 3, 1, -1, 0, 0, "jam0_empty");
    do_restock(0, 1, "unjam0");
    drain(0, mstock[0], "drain0");
    vend(0, 3, 1, -1, 0, 0, "empty0");
  endtask

  task automatic test_saturate();
    do_restock(3, 15, "sat3");
    drain(3, mstock[3] - 5, "down3");
    vend(3, 3, 1, -2, 3, 2, "rs_on_report");
    drain(3, mstock[3], "drain3");
    vend(3, 3, 1, -1, 0, 0, "empty3");
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    req_valid = 1'b1;
    req_slot = 2'd1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (motor_en !== 4'b0010) begin
      errors++;
      $display("FAIL mid_drive motor: got %b want 0010", motor_en);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (motor_en !== '0 || req_ready !== 1'b1 || done_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset outs: got mot=%b rdy=%b dv=%b want 0 1 0",
               motor_en, req_ready, done_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done_valid !== 1'b0 || motor_en !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_reset quiet: got %0d bad cycles want 0", bad);
    end
    check_status("mid_reset");
    vend(2, 5, 1, -1, 0, 0, "after_reset2");
  endtask

  task automatic test_retry();
    vend(1, M + T + 4, 1, -1, 0, 0, "retry_drop");
    do_restock(1, 0, "unjam1");
  endtask

  task automatic test_random();
    int s, c, w, rm;
    for (int k = 0; k < 40; k++) begin
      s = $urandom_range(0, NS - 1);
      c = ($urandom_range(0, 3) == 0) ? -1 :
          $urandom_range(1, 2 * (M + T) + 2);
      w = $urandom_range(1, 3);
      rm = ($urandom_range(0, 3) == 0) ? -3 : -1;
      vend(s, c, w, rm, $urandom_range(0, NS - 1),
           $urandom_range(0, 15), "rand");
      if ($urandom_range(0, 4) == 0)
        do_restock($urandom_range(0, NS - 1), $urandom_range(0, 6),
                   "rand_rs");
    end
  endtask

  initial begin
    test_reset();
    test_ok();
    test_empty();
    test_jam();
    test_saturate();
    test_reset_mid();
    test_retry();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
